// File: rtl/crc24_pkg.sv
// Shared constants and state encoding for the CRC-24 frame scheduler.
package crc24_pkg;

    localparam int unsigned CRC_W = 24;
    localparam logic [CRC_W-1:0] CRC_POLY = 24'h864CFB;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        T2   = 3'd2,
        T1   = 3'd3,
        T0   = 3'd4
    } state_t;

endpackage

// File: rtl/crc24_byte_step.sv
// One-byte CRC-24 update: MSB-first, no reflection, pure combinational.
module crc24_byte_step
    import crc24_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data_in,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] w_crc;

    // Fold the byte into the top bits, then eight shift/XOR iterations
    always_comb begin
        w_crc = crc_in ^ {data_in, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            if (w_crc[CRC_W-1]) begin
                w_crc = {w_crc[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_crc = {w_crc[CRC_W-2:0], 1'b0};
            end
        end
    end

    assign crc_out = w_crc;

endmodule

// File: rtl/crc24_frame_sched.sv
// Round-robin frame scheduler sharing one CRC-24 engine and one byte stream.
module crc24_frame_sched
    import crc24_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter logic [23:0] CRC_INIT = 24'h000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       crc_done,
    output logic [23:0]                crc_value
);

    localparam int unsigned GW = $clog2(NUM_REQ);

    state_t           r_state;
    state_t           w_next;
    logic [GW-1:0]    r_grant;
    logic [GW-1:0]    r_ptr;
    logic [GW-1:0]    w_win;
    logic [GW-1:0]    w_idx;
    logic             w_found;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_crc_step;
    logic [CRC_W-1:0] r_crc_value;
    logic             r_done;
    logic [7:0]       w_bytes [NUM_REQ];
    logic [7:0]       w_gbyte;
    logic             w_gvalid;
    logic             w_glast;
    logic             w_xfer;

    // Split the flat data bus into per-requester byte lanes
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign w_bytes[k] = req_data[8*k +: 8];
    end

    assign w_gbyte  = w_bytes[r_grant];
    assign w_gvalid = req_valid[r_grant];
    assign w_glast  = req_last[r_grant];
    assign w_xfer   = (r_state == DATA) && w_gvalid && out_ready;

    crc24_byte_step u_step (
        .crc_in  (r_crc),
        .data_in (w_gbyte),
        .crc_out (w_crc_step)
    );

    // Round-robin search starting at the pointer; first valid requester wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = GW'((32'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state and stream outputs (payload is a combinational pass-through)
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        req_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_found) w_next = DATA;
            end
            DATA: begin
                out_valid          = w_gvalid;
                out_data           = w_gbyte;
                req_ready[r_grant] = out_ready;
                if (w_xfer && w_glast) w_next = T2;
            end
            T2: begin
                out_valid = 1'b1;
                out_data  = r_crc[23:16];
                if (out_ready) w_next = T1;
            end
            T1: begin
                out_valid = 1'b1;
                out_data  = r_crc[15:8];
                if (out_ready) w_next = T0;
            end
            T0: begin
                out_valid = 1'b1;
                out_data  = r_crc[7:0];
                out_last  = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant, CRC accumulation and frame-completion bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grant     <= '0;
            r_ptr       <= '0;
            r_crc       <= CRC_INIT;
            r_crc_value <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && w_found) begin
                r_grant <= w_win;
                r_crc   <= CRC_INIT;
            end
            if (w_xfer) begin
                r_crc <= w_crc_step;
            end
            if (r_state == T0 && out_ready) begin
                r_crc_value <= r_crc;
                r_done      <= 1'b1;
                r_ptr       <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign grant_id  = r_grant;
    assign crc_done  = r_done;
    assign crc_value = r_crc_value;

endmodule

// File: tb/tb_crc24_frame_sched.sv
// Bench for crc24_frame_sched: frame-level reference model with bit-serial CRC.
module tb_crc24_frame_sched;

    localparam int NR = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_last;
    logic            out_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            crc_done;
    logic [23:0]     crc_value;

    crc24_frame_sched #(.NUM_REQ(NR), .CRC_INIT(24'h000000)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .crc_done  (crc_done),
        .crc_value (crc_value)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  src_q [NR][$];   // driver-side bytes, bit 8 = last
    logic [8:0]  mdl_q [NR][$];   // model-side copy, consumed a frame at a time
    logic [7:0]  exp_q [$];       // expected output bytes of the current frame
    logic [7:0]  fb [$];
    logic [7:0]  fb4 [$];
    int          grant_log [$];
    logic [23:0] crc_log [$];
    bit          mid [NR];
    bit          frame_act, exp_done, prev_stall, tog;
    logic [7:0]  prev_data;
    logic [23:0] exp_crc;
    int          cur_w, mdl_ptr, hold_cycles, hold_pct, ready_mode;
    int          exp_order [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Polynomial division one message bit at a time
    function automatic logic [23:0] ref_crc(input logic [7:0] msg [$]);
        logic [23:0] c;
        logic        fbk;
        c = 24'h000000;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fbk = msg[i][b] ^ c[23];
                c   = {c[22:0], 1'b0};
                if (fbk) c = c ^ 24'h864CFB;
            end
        end
        return c;
    endfunction

    task automatic enq(input int k);
        for (int i = 0; i < fb.size(); i++) begin
            src_q[k].push_back({i == fb.size() - 1, fb[i]});
            mdl_q[k].push_back({i == fb.size() - 1, fb[i]});
        end
    endtask

    task automatic rand_fb(input int len);
        fb.delete();
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    endtask

    task automatic start_frame();
        int          w;
        logic [7:0]  pay [$];
        logic [8:0]  e;
        logic [23:0] c;
        w = -1;
        for (int i = 0; i < NR; i++) begin
            if (w < 0 && mdl_q[(mdl_ptr + i) % NR].size() > 0) w = (mdl_ptr + i) % NR;
        end
        chk("grant_winner", 32'(grant_id), 32'(w));
        cur_w     = (w < 0) ? 0 : w;
        frame_act = 1'b1;
        if (w >= 0) begin
            grant_log.push_back(w);
            do begin
                e = mdl_q[w].pop_front();
                pay.push_back(e[7:0]);
            end while (!e[8] && mdl_q[w].size() > 0);
            c       = ref_crc(pay);
            exp_q   = pay;
            exp_q.push_back(c[23:16]);
            exp_q.push_back(c[15:8]);
            exp_q.push_back(c[7:0]);
            exp_crc = c;
        end
    endtask

    task automatic drive();
        logic [8:0] e;
        bit         held;
        held = 1'b0;
        for (int k = 0; k < NR; k++) begin
            req_valid[k] = 1'b0;
            if (src_q[k].size() > 0) begin
                e            = src_q[k][0];
                req_valid[k] = 1'b1;
                if (mid[k] && !prev_stall) begin
                    if (hold_cycles > 0) begin
                        req_valid[k] = 1'b0;
                        held         = 1'b1;
                    end else if (hold_pct > 0 && $urandom_range(99) < hold_pct) begin
                        req_valid[k] = 1'b0;
                    end
                end
            end else begin
                e = 9'($urandom);
            end
            req_data[8*k +: 8] = e[7:0];
            req_last[k]        = e[8];
        end
        if (held) hold_cycles--;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin tog = !tog; out_ready = tog; end
            default: out_ready = ($urandom_range(99) < 70);
        endcase
    endtask

    task automatic monitor();
        logic [8:0] e;
        logic [7:0] eb;
        bit         nxt_done;
        nxt_done = 1'b0;
        chk("ready_mask", 32'(req_ready & ~(busy ? (4'b0001 << grant_id) : 4'b0000)), 32'd0);
        if (prev_stall) chk("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
        chk("crc_done", 32'(crc_done), 32'(exp_done));
        if (exp_done) begin
            chk("crc_value", 32'(crc_value), 32'(exp_crc));
            crc_log.push_back(crc_value);
        end
        if (frame_act && !out_valid) begin
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_grant", 32'(grant_id), 32'(cur_w));
        end
        for (int k = 0; k < NR; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                e      = src_q[k].pop_front();
                mid[k] = !e[8];
            end
        end
        if (out_valid && out_ready) begin
            if (!frame_act) start_frame();
            if (exp_q.size() == 0) begin
                chk("extra_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                eb = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(eb));
                chk("out_last", 32'(out_last), 32'(exp_q.size() == 0));
                chk("out_grant", 32'(grant_id), 32'(cur_w));
                if (exp_q.size() == 0) begin
                    frame_act = 1'b0;
                    mdl_ptr   = (cur_w + 1) % NR;
                    nxt_done  = 1'b1;
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        exp_done   = nxt_done;
    endtask

    task automatic step();
        drive();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic run_until_idle(input int maxc, input string tag);
        bit fin;
        bit empty;
        fin = 1'b0;
        for (int c = 0; c < maxc && !fin; c++) begin
            empty = 1'b1;
            for (int k = 0; k < NR; k++) if (src_q[k].size() > 0) empty = 1'b0;
            if (empty && exp_q.size() == 0 && !frame_act && !busy && !exp_done) fin = 1'b1;
            else step();
        end
        chk(tag, 32'(fin), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_crc_done"}, 32'(crc_done), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_crc_value"}, 32'(crc_value), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
        frame_act = 0; exp_done = 0; prev_stall = 0; tog = 0; prev_data = 0; exp_crc = 0;
        cur_w = 0; mdl_ptr = 0; hold_cycles = 0; hold_pct = 0; ready_mode = 0;
        for (int k = 0; k < NR; k++) mid[k] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // single byte 0x01 from requester 0
        fb.delete(); fb.push_back(8'h01); enq(0);
        run_until_idle(200, "drain_tp1");
        chk("tp1_crc", 32'(crc_log[0]), 32'h00864CFB);
        chk("tp1_grant", 32'(grant_log[0]), 32'd0);

        // requester 2: 00 01, then back-to-back single 00
        grant_log.delete(); crc_log.delete();
        fb.delete(); fb.push_back(8'h00); fb.push_back(8'h01); enq(2);
        fb.delete(); fb.push_back(8'h00); enq(2);
        run_until_idle(200, "drain_tp2");
        chk("tp2_crc_a", 32'(crc_log[0]), 32'h00864CFB);
        chk("tp2_crc_b", 32'(crc_log[1]), 32'h00000000);
        chk("tp2_grant_a", 32'(grant_log[0]), 32'd2);
        chk("tp2_grant_b", 32'(grant_log[1]), 32'd2);

        // out_ready toggling, then the same payload without stalls
        grant_log.delete(); crc_log.delete();
        rand_fb(4); fb4 = fb; enq(1);
        rand_fb(3); enq(3);
        ready_mode = 1;
        run_until_idle(400, "drain_tp4_toggle");
        ready_mode = 0;
        fb = fb4; enq(1);
        run_until_idle(200, "drain_tp4_clean");
        for (int i = 0; i < grant_log.size(); i++) begin
            if (grant_log[i] == 1) chk("tp4_req1_crc", 32'(crc_log[i]), 32'(ref_crc(fb4)));
        end

        // requester 1 stalls mid-frame while requester 3 waits
        grant_log.delete(); crc_log.delete();
        rand_fb(5); enq(1);
        for (int c = 0; c < 50 && !mid[1]; c++) step();
        chk("tp5_started", 32'(mid[1]), 32'd1);
        rand_fb(2); enq(3);
        hold_cycles = 5;
        run_until_idle(300, "drain_tp5");
        chk("tp5_first", 32'(grant_log[0]), 32'd1);
        chk("tp5_second", 32'(grant_log[1]), 32'd3);

        // reset while the second trailer byte is on the output
        rand_fb(2); enq(0);
        for (int c = 0; c < 50 && !(frame_act && exp_q.size() == 2); c++) step();
        chk("t1_reached", 32'(exp_q.size()), 32'd2);
        chk("t1_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        req_valid = '0;
        #1;
        check_reset_outputs("midrst");
        for (int k = 0; k < NR; k++) begin
            src_q[k].delete(); mdl_q[k].delete(); mid[k] = 1'b0;
        end
        exp_q.delete();
        frame_act = 0; exp_done = 0; prev_stall = 0; mdl_ptr = 0; hold_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("midrst_no_done", 32'(crc_done), 32'd0);
            @(posedge clock);
            #1;
        end
        reset = 1'b0;

        // all four requesters pending from pointer 0
        grant_log.delete(); crc_log.delete();
        rand_fb(1); enq(0);
        rand_fb(1); enq(1);
        rand_fb(1); enq(2);
        rand_fb(1); enq(3);
        rand_fb(1); enq(0);
        run_until_idle(300, "drain_tp3");
        exp_order = '{0, 1, 2, 3, 0};
        chk("tp3_frames", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("tp3_order", 32'(grant_log[i]), 32'(exp_order[i]));

        // randomized frames, random backpressure and payload holes
        ready_mode = 2;
        hold_pct   = 25;
        for (int f = 0; f < 25; f++) begin
            rand_fb($urandom_range(1, 6));
            enq($urandom_range(NR - 1));
        end
        run_until_idle(5000, "drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
